// File: rtl/add_nbit_pipe.sv
// WIDTH-bit adder with carry-in, carry chain cut into CHUNK-bit stages; sum/cout/ovf out.
// Latency STAGES = ceil(WIDTH/CHUNK) cycles, one operation per cycle.
// Global stall: every stage holds while a result sits unaccepted at the output.
module add_nbit_pipe #(
    parameter int WIDTH  = 8,
    parameter int CHUNK  = 4,
    parameter int SIGNED = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int STAGES = (WIDTH + CHUNK - 1) / CHUNK;

    // Whole pipe advances unless the output holds a result nobody took.
    logic w_adv;

    assign w_adv    = !(out_valid && !out_ready);
    // Reset forces ready so the source never sees a stall during reset.
    assign in_ready = w_adv | rst;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // LO/HI: bit range handled here; R: operand bits still unprocessed on entry.
        localparam int LO = k * CHUNK;
        localparam int HI = (((LO + CHUNK) > WIDTH) ? WIDTH : (LO + CHUNK)) - 1;
        localparam int N  = HI - LO + 1;
        localparam int R  = WIDTH - LO;

        logic         w_vld_in;
        logic         w_c_in;
        logic [R-1:0] w_a_in;
        logic [R-1:0] w_b_in;
        logic [N:0]   w_add;
        logic [HI:0]  w_s_nx;

        logic         r_vld;
        logic         r_c;
        logic [HI:0]  r_s;

        if (k == 0) begin : g_in
            assign w_vld_in = in_valid;
            assign w_c_in   = cin;
            assign w_a_in   = a;
            assign w_b_in   = b;
            assign w_s_nx   = w_add[N-1:0];
        end else begin : g_in
            assign w_vld_in = g_stage[k-1].r_vld;
            assign w_c_in   = g_stage[k-1].r_c;
            assign w_a_in   = g_stage[k-1].g_ops.r_a;
            assign w_b_in   = g_stage[k-1].g_ops.r_b;
            assign w_s_nx   = {w_add[N-1:0], g_stage[k-1].r_s};
        end

        // Operand chunk is always the low N bits of what is still unprocessed.
        assign w_add = {1'b0, w_a_in[N-1:0]} + {1'b0, w_b_in[N-1:0]} + {{N{1'b0}}, w_c_in};

        // Stage valid follows the stall; payload only loads for real operations so
        // the output keeps its reset values until the first result arrives.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_vld <= 1'b0;
                r_c   <= 1'b0;
                r_s   <= '0;
            end else if (w_adv) begin
                r_vld <= w_vld_in;
                if (w_vld_in) begin
                    r_c <= w_add[N];
                    r_s <= w_s_nx;
                end
            end
        end

        if (k < STAGES - 1) begin : g_ops
            logic [R-N-1:0] r_a;
            logic [R-N-1:0] r_b;

            // Carry the untouched upper operand bits forward to later stages.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_adv && w_vld_in) begin
                    r_a <= w_a_in[R-1:N];
                    r_b <= w_b_in[R-1:N];
                end
            end
        end else begin : g_ovf
            logic r_ovf;

            // Same-sign operands giving a different-sign sum is equivalent to
            // carry-into-MSB XOR carry-out.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_ovf <= 1'b0;
                end else if (w_adv && w_vld_in) begin
                    r_ovf <= (SIGNED != 0) && (w_a_in[R-1] == w_b_in[R-1])
                             && (w_s_nx[HI] != w_a_in[R-1]);
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].r_vld;
    assign sum       = g_stage[STAGES-1].r_s;
    assign cout      = g_stage[STAGES-1].r_c;
    assign ovf       = g_stage[STAGES-1].g_ovf.r_ovf;

endmodule

// File: tb/tb_add_nbit_pipe.sv
// Bench for add_nbit_pipe over four configurations: (8,4,signed), (10,4), (1,1), (8,8,signed).
// Directed cases pin latency, stall, reset and the arithmetic; random traffic runs after.
// A slot-level pipeline model with arithmetic reference checks every DUT every cycle.
module tb_add_nbit_pipe;

    localparam int             WD  [4] = '{8, 10, 1, 8};
    localparam int             SG  [4] = '{2, 3, 1, 1};
    localparam bit             SGN [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    localparam logic [9:0]     MSK [4] = '{10'h0FF, 10'h3FF, 10'h001, 10'h0FF};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] a_r    [4];
    logic [9:0] b_r    [4];
    logic       cin_r  [4];
    logic       iv_r   [4];
    logic       ordy_r [4];
    logic       irdy   [4];
    logic       ov     [4];
    logic       co     [4];
    logic       of     [4];
    logic [9:0] sm     [4];
    logic [7:0] s0, s3;
    logic [9:0] s1;
    logic [0:0] s2;

    // Model: one slot per stage, plus delivery bookkeeping.
    logic        mv   [4][3];
    logic [11:0] mr   [4][3];
    logic        seen [4];
    logic        took [4];
    int          dlv  [4];
    bit          rnd_en = 1'b0;
    int          nchk = 0;
    int          nerr = 0;

    always #5 clk = ~clk;

    assign sm[0] = {2'b00, s0};
    assign sm[1] = s1;
    assign sm[2] = {9'b0, s2};
    assign sm[3] = {2'b00, s3};

    add_nbit_pipe #(.WIDTH(8), .CHUNK(4), .SIGNED(1)) u0 (
        .clk(clk), .rst(rst), .a(a_r[0][7:0]), .b(b_r[0][7:0]), .cin(cin_r[0]),
        .in_valid(iv_r[0]), .in_ready(irdy[0]), .sum(s0), .cout(co[0]), .ovf(of[0]),
        .out_valid(ov[0]), .out_ready(ordy_r[0]));
    add_nbit_pipe #(.WIDTH(10), .CHUNK(4), .SIGNED(0)) u1 (
        .clk(clk), .rst(rst), .a(a_r[1]), .b(b_r[1]), .cin(cin_r[1]),
        .in_valid(iv_r[1]), .in_ready(irdy[1]), .sum(s1), .cout(co[1]), .ovf(of[1]),
        .out_valid(ov[1]), .out_ready(ordy_r[1]));
    add_nbit_pipe #(.WIDTH(1), .CHUNK(1), .SIGNED(0)) u2 (
        .clk(clk), .rst(rst), .a(a_r[2][0:0]), .b(b_r[2][0:0]), .cin(cin_r[2]),
        .in_valid(iv_r[2]), .in_ready(irdy[2]), .sum(s2), .cout(co[2]), .ovf(of[2]),
        .out_valid(ov[2]), .out_ready(ordy_r[2]));
    add_nbit_pipe #(.WIDTH(8), .CHUNK(8), .SIGNED(1)) u3 (
        .clk(clk), .rst(rst), .a(a_r[3][7:0]), .b(b_r[3][7:0]), .cin(cin_r[3]),
        .in_valid(iv_r[3]), .in_ready(irdy[3]), .sum(s3), .cout(co[3]), .ovf(of[3]),
        .out_valid(ov[3]), .out_ready(ordy_r[3]));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference result {ovf, cout, sum[9:0]} from integer arithmetic.
    function automatic logic [11:0] model(input int w, input bit sg, input logic [9:0] aa,
                                          input logic [9:0] bb, input logic cc);
        int ua, ub, tot, sa, sb, st;
        logic [9:0] s;
        logic c, o;
        ua  = int'(aa) % (1 << w);
        ub  = int'(bb) % (1 << w);
        tot = ua + ub + int'(cc);
        s   = 10'(tot % (1 << w));
        c   = (tot >= (1 << w));
        sa  = (ua >= (1 << (w - 1))) ? ua - (1 << w) : ua;
        sb  = (ub >= (1 << (w - 1))) ? ub - (1 << w) : ub;
        st  = sa + sb + int'(cc);
        o   = sg && ((st > (1 << (w - 1)) - 1) || (st < -(1 << (w - 1))));
        return {o, c, s};
    endfunction

    for (genvar d = 0; d < 4; d++) begin : g_tb
        localparam int S = SG[d];
        logic e_ov, e_adv;

        // Per-cycle compare against the model, then advance the model to the next edge.
        always begin
            @(negedge clk);
            #2;
            e_ov  = mv[d][S-1];
            e_adv = !(e_ov && !ordy_r[d]);
            chk($sformatf("d%0d_out_valid", d), 32'(ov[d]), 32'(e_ov));
            if (e_ov) begin
                chk($sformatf("d%0d_result", d), {20'b0, of[d], co[d], sm[d]}, {20'b0, mr[d][S-1]});
                seen[d] = 1'b1;
            end else if (!seen[d]) begin
                chk($sformatf("d%0d_idle_regs", d), {20'b0, of[d], co[d], sm[d]}, 32'h0);
            end
            chk($sformatf("d%0d_in_ready", d), 32'(irdy[d]), 32'(rst || e_adv));
            if (rst) begin
                for (int s = 0; s < 3; s++) mv[d][s] = 1'b0;
                seen[d] = 1'b0;
                took[d] = 1'b0;
            end else begin
                took[d] = iv_r[d] && e_adv;
                if (e_ov && ordy_r[d]) dlv[d]++;
                if (e_adv) begin
                    for (int s = S - 1; s > 0; s--) begin
                        mv[d][s] = mv[d][s-1];
                        mr[d][s] = mr[d][s-1];
                    end
                    mv[d][0] = iv_r[d];
                    if (iv_r[d]) mr[d][0] = model(WD[d], SGN[d], a_r[d], b_r[d], cin_r[d]);
                end
            end
        end

        // Random source/sink; a presented but untaken operation is held.
        always @(negedge clk) begin
            if (rnd_en) begin
                if (!(iv_r[d] && !took[d])) begin
                    iv_r[d]  = ($urandom_range(0, 3) != 0);
                    a_r[d]   = 10'($urandom) & MSK[d];
                    b_r[d]   = 10'($urandom) & MSK[d];
                    cin_r[d] = 1'($urandom);
                end
                ordy_r[d] = ($urandom_range(0, 3) != 0);
            end
        end
    end

    // One operation with out_ready=1; checks exact latency and the literal result.
    task automatic one_op(input int d, input logic [9:0] aa, input logic [9:0] bb, input logic cc,
                          input int lat, input logic [9:0] es, input logic ec, input logic eo,
                          input string nm);
        @(negedge clk);
        a_r[d] = aa; b_r[d] = bb; cin_r[d] = cc; iv_r[d] = 1'b1; ordy_r[d] = 1'b1;
        for (int i = 1; i <= lat; i++) begin
            @(negedge clk);
            iv_r[d] = 1'b0;
            #1;
            if (i < lat) begin
                chk({nm, "_early_valid"}, 32'(ov[d]), 32'h0);
            end else begin
                chk({nm, "_valid"}, 32'(ov[d]), 32'h1);
                chk({nm, "_sum"}, 32'(sm[d]), 32'(es));
                chk({nm, "_cout_ovf"}, {30'b0, co[d], of[d]}, {30'b0, ec, eo});
            end
        end
    endtask

    task automatic put0(input logic [9:0] v, input logic vld);
        a_r[0] = v; b_r[0] = v; cin_r[0] = 1'b0; iv_r[0] = vld;
    endtask

    initial begin
        bit done;
        for (int d = 0; d < 4; d++) begin
            a_r[d] = '0; b_r[d] = '0; cin_r[d] = 1'b0; iv_r[d] = 1'b0; ordy_r[d] = 1'b1;
            seen[d] = 1'b0; took[d] = 1'b0; dlv[d] = 0;
            for (int s = 0; s < 3; s++) begin
                mv[d][s] = 1'b0;
                mr[d][s] = '0;
            end
        end

        // Pin the reference arithmetic with hand-computed values.
        chk("model_ff_01", 32'(model(8, 1'b1, 10'h0FF, 10'h001, 1'b0)), 32'h400);
        chk("model_7f_01", 32'(model(8, 1'b1, 10'h07F, 10'h001, 1'b0)), 32'h880);
        chk("model_80_ff", 32'(model(8, 1'b1, 10'h080, 10'h0FF, 1'b0)), 32'hC7F);
        chk("model_w10",   32'(model(10, 1'b0, 10'h3FF, 10'h001, 1'b1)), 32'h401);

        repeat (3) @(negedge clk);
        #1;
        chk("rst_in_ready", 32'(irdy[0]), 32'h1);
        chk("rst_out", {21'b0, ov[0], sm[0]}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        one_op(0, 10'h0FF, 10'h001, 1'b0, 2, 10'h000, 1'b1, 1'b0, "t1");
        one_op(0, 10'h07F, 10'h001, 1'b0, 2, 10'h080, 1'b0, 1'b1, "t2a");
        one_op(0, 10'h080, 10'h0FF, 1'b0, 2, 10'h07F, 1'b1, 1'b1, "t2b");
        one_op(1, 10'h3FF, 10'h001, 1'b1, 3, 10'h001, 1'b1, 1'b0, "t5");
        one_op(2, 10'h001, 10'h001, 1'b1, 1, 10'h001, 1'b1, 1'b0, "w1");
        one_op(3, 10'h080, 10'h0FF, 1'b0, 1, 10'h07F, 1'b1, 1'b1, "w8c8");

        // Stall with out_ready=0, then release and drain in order.
        @(negedge clk); ordy_r[0] = 1'b0; put0(10'd1, 1'b1); #1; chk("t3_rdy1", 32'(irdy[0]), 32'h1);
        @(negedge clk); put0(10'd2, 1'b1); #1; chk("t3_rdy2", 32'(irdy[0]), 32'h1);
        @(negedge clk); put0(10'd3, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t3_hold", {23'b0, irdy[0], ov[0], sm[0][7:0]}, 32'h102);
            @(negedge clk);
        end
        ordy_r[0] = 1'b1; #1; chk("t3_rel02", {23'b0, irdy[0], ov[0], sm[0][7:0]}, 32'h302);
        @(negedge clk); put0(10'd4, 1'b1); #1; chk("t3_out04", {23'b0, ov[0], sm[0][7:0]}, 32'h104);
        @(negedge clk); put0(10'd0, 1'b0); #1; chk("t3_out06", {23'b0, ov[0], sm[0][7:0]}, 32'h106);
        @(negedge clk); #1; chk("t3_out08", {23'b0, ov[0], sm[0][7:0]}, 32'h108);
        @(negedge clk); #1; chk("t3_empty", 32'(ov[0]), 32'h0);

        // Two ops in flight, reset before either transfers; reset-cycle input dropped.
        @(negedge clk); ordy_r[0] = 1'b0; put0(10'd5, 1'b1);
        @(negedge clk); put0(10'd6, 1'b1);
        @(negedge clk); put0(10'd7, 1'b1); rst = 1'b1; #1;
        chk("t4_rst_rdy", 32'(irdy[0]), 32'h1);
        @(negedge clk); rst = 1'b0; ordy_r[0] = 1'b1; put0(10'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t4_flushed", {21'b0, irdy[0], ov[0], sm[0][7:0]}, 32'h200);
            @(negedge clk);
        end

        // Randomised traffic on all four configurations.
        #1;
        for (int d = 0; d < 4; d++) dlv[d] = 0;
        rnd_en = 1'b1;
        done = 1'b0;
        for (int cyc = 0; cyc < 5000 && !done; cyc++) begin
            @(negedge clk);
            done = (dlv[0] >= 125) && (dlv[1] >= 125) && (dlv[2] >= 125) && (dlv[3] >= 125);
        end
        chk("random_500_ops_delivered", 32'(done), 32'h1);
        #1;
        rnd_en = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            iv_r[d] = 1'b0;
            ordy_r[d] = 1'b1;
        end
        repeat (5) @(negedge clk);
        #3;
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
